alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Registered, clock-enabled integer ALU with two N-bit operands and a mode select (arithmetic vs logic).
- Produces a 2N-bit result plus carry, overflow, compare and error flags.
- Sits behind the bench interface; all outputs are registered, and the block has no internal state beyond the pipeline registers.

Parameters:
- N, 8, operand width in bits (power of 2, at least 4).
- CMD_W, 4, width of the command field.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  asynchronous active-low reset.
- CE  in  1  clock enable; when low, all registers hold.
- INP_VALID  in  2  operand-valid bits: 00 none, 01 OPA only, 10 OPB only, 11 both.
- MODE  in  1  1 = arithmetic, 0 = logic.
- CMD  in  CMD_W  operation code.
- CIN  in  1  carry in.
- OPA  in  N  operand A.
- OPB  in  N  operand B.
- RES  out  2N  result, zero-extended unless stated.
- COUT  out  1  carry out.
- OFLOW  out  1  overflow/borrow.
- G  out  1  A>B.
- L  out  1  A<B.
- E  out  1  A==B.
- ERR  out  1  illegal command or operand-valid mismatch.

Behaviour:
- Reset (RST=0, asynchronous): RES=0 and all flags are 0. Reset takes precedence over CE and cancels any in-flight multiply.
- Inputs are sampled on the rising CLK edge when CE=1. Outputs update 1 cycle later.
- Multiply ops take 2 cycles: outputs update on the 2nd edge after sampling. Any new sample during that cycle is ignored.
- Every update first clears all flags, then sets only the flags relevant to the operation.
- Arithmetic operations (MODE=1):
  - 0 ADD: A+B. COUT = carry.
  - 1 SUB: A-B. OFLOW = 1 when A<B.
  - 2 ADD_CIN: A+B+CIN. COUT = carry.
  - 3 SUB_CIN: A-B-CIN. OFLOW = borrow.
  - 4 INC_A, 5 DEC_A: need OPA valid.
  - 6 INC_B, 7 DEC_B: need OPB valid.
  - 8 CMP: sets G/L/E; RES=0.
  - 9 MUL_INC: (A+1)*(B+1), truncated to 2N bits.
  - 10 MUL_SHL: (A<<1, N-bit truncated)*B.
  - Add results occupy RES[N:0]; subtract results are N-bit two's-complement, zero-extended.
- Logic operations (MODE=0), results N bits, zero-extended:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
  - 12 ROL_A_B: rotate A left by OPB[log2N-1:0].
  - 13 ROR_A_B: rotate A right by OPB[log2N-1:0].
- Operand validity:
  - Single-operand ops need their operand's valid bit set.
  - Two-operand ops need INP_VALID=11.
  - A mismatch gives ERR=1, RES=0.
  - INP_VALID=00 with CE=1 gives ERR=1.
- Other ERR conditions (RES=0, other flags 0):
  - An unlisted CMD for the current MODE.
  - For rotates, any of OPB[N-1:log2N] nonzero.
- Wrap-around:
  - INC of all-ones gives 0 in RES[N-1:0] with RES[N]=1.
  - DEC of 0 gives all-ones in RES[N-1:0] and OFLOW=1.
  - Shifts drop the shifted-out bit and fill with 0.
- CE falling during a multiply: the pending result still completes once CE returns high; it is held while CE=0.

Optional Feature:
- Macro: ALU_MULT_EN.
- Defined: arithmetic CMD 9 and 10 are implemented with 2-cycle latency as described above.
- Undefined: no multiplier is synthesised. CMD 9/10 with MODE=1 return ERR=1, RES=0 with 1-cycle latency. RES[2N-1:N+1] is then always 0.

Test Plan:
- RST=0 mid-run, then RST=1 -> all outputs 0 immediately, with no clock needed. The first valid op after release updates 1 cycle later.
- MODE=1, CMD=0, A=8'hFF, B=8'h01, INP_VALID=11 -> RES=9'h100, COUT=1, next cycle.
- MODE=1, CMD=8, A=5, B=9 -> L=1, G=0, E=0, RES=0. A=B=7 -> E=1.
- MODE=1, CMD=9, A=3, B=4, ALU_MULT_EN defined -> RES=20, 2 cycles after sampling. Without the macro -> ERR=1.
- MODE=0, CMD=12, A=8'h81, B=8'h01 -> RES=8'h03. Same with B=8'h11 -> ERR=1, RES=0.
- MODE=1, CMD=4 (INC_A), INP_VALID=10 -> ERR=1. Same with INP_VALID=01, A=8'hFF -> RES=9'h100. MODE=0, CMD=15 -> ERR=1.

Source files
------------

// File: rtl/alu_core.sv
// alu_core: registered, clock-enabled integer ALU with arithmetic and logic modes.
// All outputs are registered. Every update clears the flags and then sets only
// the flags that belong to the operation.
// Build option: define ALU_MULT_EN to include the 2-cycle multiplier (arith CMD 9/10).
// Without it, those commands report ERR and no multiplier is built.
module alu_core #(
  parameter int N     = 8,
  parameter int CMD_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [1:0]       INP_VALID,
  input  logic             MODE,
  input  logic [CMD_W-1:0] CMD,
  input  logic             CIN,
  input  logic [N-1:0]     OPA,
  input  logic [N-1:0]     OPB,
  output logic [2*N-1:0]   RES,
  output logic             COUT,
  output logic             OFLOW,
  output logic             G,
  output logic             L,
  output logic             E,
  output logic             ERR
);

  localparam int SH_W = $clog2(N);
  localparam logic [N-1:0] ONE_N  = N'(1);
  localparam logic [N:0]   ONE_N1 = (N+1)'(1);

  typedef enum logic [CMD_W-1:0] {
    A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_INC_A, A_DEC_A, A_INC_B, A_DEC_B,
    A_CMP, A_MUL_INC, A_MUL_SHL
  } arith_cmd_e;

  typedef enum logic [CMD_W-1:0] {
    L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_NOT_A, L_NOT_B,
    L_SHR1_A, L_SHL1_A, L_SHR1_B, L_SHL1_B, L_ROL, L_ROR
  } logic_cmd_e;

  logic [N:0]     add_ab, add_abc, sub_ab, sub_abc;
  logic [2*N-1:0] rol_w, ror_w;
  logic           rot_bad;

  logic [2*N-1:0] d_res;
  logic           d_cout, d_oflow, d_g, d_l, d_e, d_err;
  logic           need_a, need_b, legal, op_ok;
  logic           load_dec;

  assign add_ab  = {1'b0, OPA} + {1'b0, OPB};
  assign add_abc = add_ab + {{N{1'b0}}, CIN};
  // Bit N of the (N+1)-bit difference is the borrow.
  assign sub_ab  = {1'b0, OPA} - {1'b0, OPB};
  assign sub_abc = sub_ab - {{N{1'b0}}, CIN};
  // Rotation via a doubled copy of A: the wrapped bits land in the kept half.
  assign rol_w   = {OPA, OPA} << OPB[SH_W-1:0];
  assign ror_w   = {OPA, OPA} >> OPB[SH_W-1:0];
  assign rot_bad = |(OPB >> SH_W);

`ifdef ALU_MULT_EN
  localparam logic [2*N-1:0] ONE_2N = (2*N)'(1);

  typedef enum logic {ST_IDLE, ST_MUL} state_e;
  state_e         state, state_nxt;
  logic           d_mul, cap_mul, load_mul;
  logic [N-1:0]   mul_a, mul_b;
  logic           mul_shl;
  logic [2*N-1:0] mul_x, mul_y, mul_p;
`endif

  // Decode the sampled command: legality, operand validity and single-cycle result.
  always_comb begin
    d_res  = '0;
    d_cout = 1'b0;
    d_oflow = 1'b0;
    d_g    = 1'b0;
    d_l    = 1'b0;
    d_e    = 1'b0;
    d_err  = 1'b0;
    need_a = 1'b0;
    need_b = 1'b0;
    legal  = 1'b1;
`ifdef ALU_MULT_EN
    d_mul  = 1'b0;
`endif
    if (MODE) begin
      case (CMD)
        A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: begin need_a = 1'b1; need_b = 1'b1; end
        A_INC_A, A_DEC_A: need_a = 1'b1;
        A_INC_B, A_DEC_B: need_b = 1'b1;
`ifdef ALU_MULT_EN
        A_MUL_INC, A_MUL_SHL: begin need_a = 1'b1; need_b = 1'b1; end
`endif
        default: legal = 1'b0;
      endcase
    end else begin
      case (CMD)
        L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_ROL, L_ROR: begin
          need_a = 1'b1;
          need_b = 1'b1;
        end
        L_NOT_A, L_SHR1_A, L_SHL1_A: need_a = 1'b1;
        L_NOT_B, L_SHR1_B, L_SHL1_B: need_b = 1'b1;
        default: legal = 1'b0;
      endcase
    end

    op_ok = legal && (!need_a || INP_VALID[0]) && (!need_b || INP_VALID[1])
            && !(!MODE && (CMD == L_ROL || CMD == L_ROR) && rot_bad);

    if (!op_ok) begin
      d_err = 1'b1;
    end else if (MODE) begin
      case (CMD)
        A_ADD:     begin d_res[N:0] = add_ab;  d_cout = add_ab[N]; end
        A_SUB:     begin d_res[N-1:0] = sub_ab[N-1:0];  d_oflow = sub_ab[N]; end
        A_ADD_CIN: begin d_res[N:0] = add_abc; d_cout = add_abc[N]; end
        A_SUB_CIN: begin d_res[N-1:0] = sub_abc[N-1:0]; d_oflow = sub_abc[N]; end
        A_INC_A:   d_res[N:0] = {1'b0, OPA} + ONE_N1;
        A_DEC_A:   begin d_res[N-1:0] = OPA - ONE_N; d_oflow = (OPA == '0); end
        A_INC_B:   d_res[N:0] = {1'b0, OPB} + ONE_N1;
        A_DEC_B:   begin d_res[N-1:0] = OPB - ONE_N; d_oflow = (OPB == '0); end
        A_CMP:     begin d_g = (OPA > OPB); d_l = (OPA < OPB); d_e = (OPA == OPB); end
`ifdef ALU_MULT_EN
        A_MUL_INC, A_MUL_SHL: d_mul = 1'b1;
`endif
        default: ;
      endcase
    end else begin
      case (CMD)
        L_AND:    d_res[N-1:0] = OPA & OPB;
        L_NAND:   d_res[N-1:0] = ~(OPA & OPB);
        L_OR:     d_res[N-1:0] = OPA | OPB;
        L_NOR:    d_res[N-1:0] = ~(OPA | OPB);
        L_XOR:    d_res[N-1:0] = OPA ^ OPB;
        L_XNOR:   d_res[N-1:0] = ~(OPA ^ OPB);
        L_NOT_A:  d_res[N-1:0] = ~OPA;
        L_NOT_B:  d_res[N-1:0] = ~OPB;
        L_SHR1_A: d_res[N-1:0] = OPA >> 1;
        L_SHL1_A: d_res[N-1:0] = OPA << 1;
        L_SHR1_B: d_res[N-1:0] = OPB >> 1;
        L_SHL1_B: d_res[N-1:0] = OPB << 1;
        L_ROL:    d_res[N-1:0] = rol_w[2*N-1:N];
        L_ROR:    d_res[N-1:0] = ror_w[N-1:0];
        default: ;
      endcase
    end
  end

`ifdef ALU_MULT_EN
  // Product of the captured operands; both forms fit in 2N bits after truncation.
  assign mul_x = mul_shl ? {{N{1'b0}}, mul_a << 1} : {{N{1'b0}}, mul_a} + ONE_2N;
  assign mul_y = mul_shl ? {{N{1'b0}}, mul_b}      : {{N{1'b0}}, mul_b} + ONE_2N;
  assign mul_p = mul_x * mul_y;

  // Multiply sequencer state; holds with CE low, reset cancels a pending product.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)    state <= ST_IDLE;
    else if (CE) state <= state_nxt;
  end

  // Next state: a multiply occupies one extra cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (d_mul) state_nxt = ST_MUL;
      ST_MUL:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control: capture operands, load decoded result, or load product.
  always_comb begin
    cap_mul  = 1'b0;
    load_dec = 1'b0;
    load_mul = 1'b0;
    case (state)
      ST_IDLE: if (d_mul) cap_mul = 1'b1; else load_dec = 1'b1;
      ST_MUL:  load_mul = 1'b1;
      default: ;
    endcase
  end

  // Operand capture for the multiplier.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_shl <= 1'b0;
    end else if (CE && cap_mul) begin
      mul_a   <= OPA;
      mul_b   <= OPB;
      mul_shl <= (CMD == A_MUL_SHL);
    end
  end
`else
  assign load_dec = 1'b1;
`endif

  // Output registers: reset wins over CE; each load rewrites every flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RES <= '0; COUT <= 1'b0; OFLOW <= 1'b0; G <= 1'b0; L <= 1'b0; E <= 1'b0; ERR <= 1'b0;
    end else if (CE) begin
`ifdef ALU_MULT_EN
      if (load_mul) begin
        RES <= mul_p; COUT <= 1'b0; OFLOW <= 1'b0; G <= 1'b0; L <= 1'b0; E <= 1'b0; ERR <= 1'b0;
      end else
`endif
      if (load_dec) begin
        RES <= d_res; COUT <= d_cout; OFLOW <= d_oflow;
        G <= d_g; L <= d_l; E <= d_e; ERR <= d_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and randomized checks of alu_core against an
// arithmetic reference model. Honours ALU_MULT_EN the same way as the design.
module tb_alu_core;

  localparam int N    = 8;
  localparam int MASK = (1 << N) - 1;

  typedef struct packed {
    logic [2*N-1:0] res;
    logic           cout;
    logic           oflow;
    logic           gt;
    logic           lt;
    logic           eq;
    logic           err;
  } exp_t;

  logic           CLK, RST, CE, MODE, CIN;
  logic [1:0]     INP_VALID;
  logic [3:0]     CMD;
  logic [N-1:0]   OPA, OPB;
  logic [2*N-1:0] RES;
  logic           COUT, OFLOW, G, L, E, ERR;

  int   total = 0;
  int   bad   = 0;
  exp_t cur;

  alu_core #(.N(N), .CMD_W(4)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
    .CMD(CMD), .CIN(CIN), .OPA(OPA), .OPB(OPB),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: results straight from the operation definitions, in integers.
  function automatic exp_t model(input logic m, input int cmd, input logic [1:0] iv,
                                 input logic ci, input int a, input int b, output logic mul);
    exp_t x;
    bit   na, nb, ok;
    int   r;
    x = '0; mul = 1'b0; na = 0; nb = 0; ok = 1;
    if (m) begin
      if (cmd inside {[0:3], [8:10]}) begin na = 1; nb = 1; end
      else if (cmd inside {4, 5})     na = 1;
      else if (cmd inside {6, 7})     nb = 1;
      else ok = 0;
`ifndef ALU_MULT_EN
      if (cmd inside {9, 10}) ok = 0;
`endif
    end else begin
      if (cmd inside {[0:5], 12, 13}) begin na = 1; nb = 1; end
      else if (cmd inside {6, 8, 9})  na = 1;
      else if (cmd inside {7, 10, 11}) nb = 1;
      else ok = 0;
      if (cmd inside {12, 13} && b >= N) ok = 0;
    end
    if ((na && !iv[0]) || (nb && !iv[1])) ok = 0;
    if (!ok) begin
      x.err = 1'b1;
      return x;
    end
    if (m) begin
      case (cmd)
        0:  begin r = a + b; x.res = (2*N)'(r); x.cout = (r > MASK); end
        1:  begin x.res = (2*N)'((a - b) & MASK); x.oflow = (a < b); end
        2:  begin r = a + b + int'(ci); x.res = (2*N)'(r); x.cout = (r > MASK); end
        3:  begin r = a - b - int'(ci); x.res = (2*N)'(r & MASK); x.oflow = (r < 0); end
        4:  x.res = (2*N)'(a + 1);
        5:  begin x.res = (2*N)'((a - 1) & MASK); x.oflow = (a == 0); end
        6:  x.res = (2*N)'(b + 1);
        7:  begin x.res = (2*N)'((b - 1) & MASK); x.oflow = (b == 0); end
        8:  begin x.gt = (a > b); x.lt = (a < b); x.eq = (a == b); end
        9:  begin mul = 1'b1; x.res = (2*N)'((a + 1) * (b + 1)); end
        10: begin mul = 1'b1; x.res = (2*N)'(((a * 2) & MASK) * b); end
        default: ;
      endcase
    end else begin
      case (cmd)
        0:  x.res = (2*N)'(a & b);
        1:  x.res = (2*N)'(~(a & b) & MASK);
        2:  x.res = (2*N)'(a | b);
        3:  x.res = (2*N)'(~(a | b) & MASK);
        4:  x.res = (2*N)'(a ^ b);
        5:  x.res = (2*N)'(~(a ^ b) & MASK);
        6:  x.res = (2*N)'(~a & MASK);
        7:  x.res = (2*N)'(~b & MASK);
        8:  x.res = (2*N)'(a >> 1);
        9:  x.res = (2*N)'((a << 1) & MASK);
        10: x.res = (2*N)'(b >> 1);
        11: x.res = (2*N)'((b << 1) & MASK);
        12: x.res = (2*N)'(((a << b) | (a >> (N - b))) & MASK);
        13: x.res = (2*N)'(((a >> b) | (a << (N - b))) & MASK);
        default: ;
      endcase
    end
    return x;
  endfunction

  task automatic check(input string tag, input exp_t want);
    exp_t got;
    got = {RES, COUT, OFLOW, G, L, E, ERR};
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed res=%h cout=%b oflow=%b g=%b l=%b e=%b err=%b, expected res=%h cout=%b oflow=%b g=%b l=%b e=%b err=%b",
             tag, got.res, got.cout, got.oflow, got.gt, got.lt, got.eq, got.err,
             want.res, want.cout, want.oflow, want.gt, want.lt, want.eq, want.err);
    end
  endtask

  task automatic drive_random();
    MODE      = 1'($urandom_range(0, 1));
    CMD       = 4'($urandom_range(0, 15));
    INP_VALID = 2'($urandom_range(0, 3));
    CIN       = 1'($urandom_range(0, 1));
    OPA       = 8'($urandom_range(0, 255));
    OPB       = 8'($urandom_range(0, 255));
  endtask

  // One sampled operation; multiplies are checked for hold then for the product.
  task automatic step(input string tag, input logic m, input logic [3:0] c, input logic [1:0] iv,
                      input logic ci, input logic [7:0] a, input logic [7:0] b);
    exp_t want;
    logic mul;
    @(negedge CLK);
    CE = 1'b1; MODE = m; CMD = c; INP_VALID = iv; CIN = ci; OPA = a; OPB = b;
    want = model(m, int'(c), iv, ci, int'(a), int'(b), mul);
    @(posedge CLK); #1;
    if (mul) begin
      check({tag, "_busy"}, cur);
      @(negedge CLK);
      drive_random();
      @(posedge CLK); #1;
    end
    cur = want;
    check(tag, cur);
  endtask

  task automatic hold_step(input string tag);
    @(negedge CLK);
    CE = 1'b0;
    drive_random();
    @(posedge CLK); #1;
    check(tag, cur);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       m, ci;
    logic [1:0] iv;
    logic [3:0] c;
    logic [7:0] a, b;

    RST = 1'b0; CE = 1'b0; MODE = 1'b0; CMD = '0; INP_VALID = '0; CIN = 1'b0; OPA = '0; OPB = '0;
    cur = '0;
    #12;
    check("reset_state", cur);
    @(negedge CLK);
    RST = 1'b1;

    step("add_ff_01",       1'b1, 4'd0,  2'b11, 1'b0, 8'hFF, 8'h01);
    step("sub_borrow",      1'b1, 4'd1,  2'b11, 1'b0, 8'h03, 8'h05);
    step("add_cin_max",     1'b1, 4'd2,  2'b11, 1'b1, 8'hFF, 8'hFF);
    step("sub_cin_borrow",  1'b1, 4'd3,  2'b11, 1'b1, 8'h05, 8'h05);
    step("cmp_lt",          1'b1, 4'd8,  2'b11, 1'b0, 8'd5,  8'd9);
    step("cmp_eq",          1'b1, 4'd8,  2'b11, 1'b0, 8'd7,  8'd7);
    step("cmp_gt",          1'b1, 4'd8,  2'b11, 1'b0, 8'd9,  8'd5);
    step("mul_inc_3_4",     1'b1, 4'd9,  2'b11, 1'b0, 8'd3,  8'd4);
    step("mul_shl",         1'b1, 4'd10, 2'b11, 1'b0, 8'hC1, 8'h03);
    step("mul_inc_max",     1'b1, 4'd9,  2'b11, 1'b0, 8'hFF, 8'hFF);
    step("rol_81_1",        1'b0, 4'd12, 2'b11, 1'b0, 8'h81, 8'h01);
    step("rol_bad_amount",  1'b0, 4'd12, 2'b11, 1'b0, 8'h81, 8'h11);
    step("ror_81_1",        1'b0, 4'd13, 2'b11, 1'b0, 8'h81, 8'h01);
    step("inc_a_b_only",    1'b1, 4'd4,  2'b10, 1'b0, 8'hFF, 8'h00);
    step("inc_a_wrap",      1'b1, 4'd4,  2'b01, 1'b0, 8'hFF, 8'h00);
    step("dec_a_wrap",      1'b1, 4'd5,  2'b01, 1'b0, 8'h00, 8'h00);
    step("inc_b_wrap",      1'b1, 4'd6,  2'b10, 1'b0, 8'h00, 8'hFF);
    step("dec_b_a_only",    1'b1, 4'd7,  2'b01, 1'b0, 8'h00, 8'h10);
    step("logic_cmd15",     1'b0, 4'd15, 2'b11, 1'b0, 8'h12, 8'h34);
    step("arith_cmd11",     1'b1, 4'd11, 2'b11, 1'b0, 8'h12, 8'h34);
    step("valid_none",      1'b0, 4'd6,  2'b00, 1'b0, 8'h12, 8'h34);
    step("and_one_valid",   1'b0, 4'd0,  2'b01, 1'b0, 8'hF0, 8'h3C);
    step("nand",            1'b0, 4'd1,  2'b11, 1'b0, 8'hF0, 8'h3C);
    step("shl1_a_drop",     1'b0, 4'd9,  2'b01, 1'b0, 8'h81, 8'h00);
    step("shr1_b_drop",     1'b0, 4'd10, 2'b10, 1'b0, 8'h00, 8'h81);
    hold_step("ce_low_hold");

    // Asynchronous reset mid-run, held across an edge with CE high.
    step("pre_reset_add",   1'b1, 4'd0,  2'b11, 1'b0, 8'h12, 8'h34);
    @(negedge CLK);
    CE = 1'b1;
    #1 RST = 1'b0;
    cur = '0;
    #1 check("reset_async", cur);
    @(posedge CLK); #1;
    check("reset_over_ce", cur);
    @(negedge CLK);
    RST = 1'b1; CE = 1'b0;
    step("post_reset_xor",  1'b0, 4'd4,  2'b11, 1'b0, 8'hA5, 8'h0F);

`ifdef ALU_MULT_EN
    // CE dropped while a product is pending: held, then completes once CE returns.
    @(negedge CLK);
    CE = 1'b1; MODE = 1'b1; CMD = 4'd9; INP_VALID = 2'b11; OPA = 8'd10; OPB = 8'd20;
    @(posedge CLK); #1;
    check("mul_ce_first", cur);
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge CLK);
      CE = 1'b0;
      drive_random();
      @(posedge CLK); #1;
      check("mul_ce_low_hold", cur);
    end
    @(negedge CLK);
    CE = 1'b1;
    drive_random();
    @(posedge CLK); #1;
    cur = '0;
    cur.res = 16'd231;
    check("mul_ce_resume", cur);

    // Reset during a pending multiply cancels it.
    @(negedge CLK);
    CE = 1'b1; MODE = 1'b1; CMD = 4'd9; INP_VALID = 2'b11; OPA = 8'd3; OPB = 8'd4;
    @(posedge CLK); #1;
    @(negedge CLK);
    RST = 1'b0; CE = 1'b0;
    cur = '0;
    #1 check("mul_reset_clear", cur);
    RST = 1'b1;
    step("mul_reset_cancel", 1'b1, 4'd0, 2'b11, 1'b0, 8'd1, 8'd2);
`endif

    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        hold_step("rand_hold");
      end else begin
        m  = 1'($urandom_range(0, 1));
        c  = 4'($urandom_range(0, 15));
        iv = ($urandom_range(0, 4) >= 2) ? 2'b11 : 2'($urandom_range(0, 3));
        ci = 1'($urandom_range(0, 1));
        a  = 8'($urandom_range(0, 255));
        b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
        step("rand_op", m, c, iv, ci, a, b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
